// File: rtl/ws2812b_receiver_if.sv
// Serial input and frame-buffer write port of the WS2812B receiver.
// The receiver uses the slave modport; whatever drives the line uses master.
interface ws2812b_receiver_if;
  logic        din;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [23:0] ram_data;
  logic        frame_done;
  logic [10:0] pixel_count;
  logic        error;

  modport slave (
    input  din,
    output ram_we, ram_addr, ram_data, frame_done, pixel_count, error
  );

  modport master (
    output din,
    input  ram_we, ram_addr, ram_data, frame_done, pixel_count, error
  );
endinterface

// File: rtl/ws2812b_receiver.sv
// WS2812B serial decoder: measures high-pulse widths on a synchronized line,
// assembles 24-bit pixels and writes them to a frame buffer, one frame per latch.
module ws2812b_receiver #(
  parameter int BIT_THRESH   = 12,
  parameter int GLITCH_MAX   = 2,
  parameter int LATCH_CYCLES = 1000,
  parameter int HIGH_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               reset,
  ws2812b_receiver_if.slave  bus
);

  localparam int LOW_W  = $clog2(LATCH_CYCLES + 1);
  localparam int HIGH_W = $clog2(HIGH_TIMEOUT + 1);

  localparam logic [LOW_W-1:0]  LATCH_L   = LOW_W'(LATCH_CYCLES);
  localparam logic [HIGH_W-1:0] TIMEOUT_H = HIGH_W'(HIGH_TIMEOUT);
  localparam logic [HIGH_W-1:0] GLITCH_H  = HIGH_W'(GLITCH_MAX);
  localparam logic [HIGH_W-1:0] THRESH_H  = HIGH_W'(BIT_THRESH);
  localparam logic [10:0]       ADDR_FULL = 11'd1024;

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  state_t            state, nxt_state;
  logic              din_m, din_s;
  logic [LOW_W-1:0]  low_cnt;
  logic [HIGH_W-1:0] high_cnt;
  logic [23:0]       shift;
  logic [23:0]       shift_nxt;
  logic [4:0]        bit_cnt;
  logic [10:0]       addr;
  logic              frame_active;

  logic              low_hit;
  logic              bit_evt, bit_val, eof_evt, timeout_evt;

  logic              ram_we_r;
  logic [9:0]        ram_addr_r;
  logic [23:0]       ram_data_r;
  logic              frame_done_r;
  logic [10:0]       pixel_count_r;
  logic              error_r;

  function automatic logic [LOW_W-1:0] sat_inc_low(input logic [LOW_W-1:0] v);
    return (v == LATCH_L) ? v : v + 1'b1;
  endfunction

  function automatic logic [HIGH_W-1:0] sat_inc_high(input logic [HIGH_W-1:0] v);
    return (v == TIMEOUT_H) ? v : v + 1'b1;
  endfunction

  assign low_hit   = (low_cnt == LATCH_L - 1'b1);
  assign shift_nxt = {shift[22:0], bit_val};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state   = state;
    bit_evt     = 1'b0;
    bit_val     = 1'b0;
    eof_evt     = 1'b0;
    timeout_evt = 1'b0;
    unique case (state)
      SYNC: begin
        if (!din_s && low_hit) nxt_state = LOW;
      end
      LOW: begin
        if (din_s)                      nxt_state = HIGH;
        else if (low_hit && frame_active) eof_evt = 1'b1;
      end
      HIGH: begin
        if (din_s) begin
          if (high_cnt == TIMEOUT_H - 1'b1) begin
            timeout_evt = 1'b1;
            nxt_state   = SYNC;
          end
        end else begin
          nxt_state = LOW;
          bit_evt   = (high_cnt > GLITCH_H);
          bit_val   = (high_cnt >= THRESH_H);
        end
      end
      default: nxt_state = SYNC;
    endcase
  end

  // Synchronizer and pulse-width counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_m    <= 1'b0;
      din_s    <= 1'b0;
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      din_m <= bus.din;
      din_s <= din_m;
      unique case (state)
        SYNC: low_cnt <= din_s ? '0 : sat_inc_low(low_cnt);
        LOW: begin
          if (din_s) high_cnt <= HIGH_W'(1);
          else       low_cnt  <= sat_inc_low(low_cnt);
        end
        HIGH: begin
          if (!din_s)          low_cnt  <= LOW_W'(1);
          else if (timeout_evt) low_cnt <= '0;
          else                 high_cnt <= sat_inc_high(high_cnt);
        end
        default: ;
      endcase
    end
  end

  // Pixel assembly, frame-buffer writes and frame bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift         <= '0;
      bit_cnt       <= '0;
      addr          <= '0;
      frame_active  <= 1'b0;
      ram_we_r      <= 1'b0;
      ram_addr_r    <= '0;
      ram_data_r    <= '0;
      frame_done_r  <= 1'b0;
      pixel_count_r <= '0;
      error_r       <= 1'b0;
    end else begin
      ram_we_r     <= 1'b0;
      frame_done_r <= 1'b0;
      if (bit_evt) begin
        frame_active <= 1'b1;
        // First bit of a new frame clears the previous frame's error.
        if (!frame_active) error_r <= 1'b0;
        if (bit_cnt == 5'd23) begin
          bit_cnt <= '0;
          shift   <= '0;
          if (addr == ADDR_FULL) begin
            error_r <= 1'b1;
          end else begin
            ram_we_r   <= 1'b1;
            ram_data_r <= shift_nxt;
            ram_addr_r <= addr[9:0];
            addr       <= addr + 1'b1;
          end
        end else begin
          shift   <= shift_nxt;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (eof_evt) begin
        frame_done_r  <= 1'b1;
        pixel_count_r <= addr;
        addr          <= '0;
        bit_cnt       <= '0;
        shift         <= '0;
        frame_active  <= 1'b0;
        if (bit_cnt != 5'd0) error_r <= 1'b1;
      end else if (timeout_evt) begin
        // A stuck-high line aborts the whole frame; decoding restarts after resync.
        error_r      <= 1'b1;
        bit_cnt      <= '0;
        shift        <= '0;
        addr         <= '0;
        frame_active <= 1'b0;
      end
    end
  end

  assign bus.ram_we      = ram_we_r;
  assign bus.ram_addr    = ram_addr_r;
  assign bus.ram_data    = ram_data_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.pixel_count = pixel_count_r;
  assign bus.error       = error_r;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Directed bench for ws2812b_receiver: frame table plus timeout, reset and
// buffer-overflow sequences (the overflow run uses a short-timing instance).
module tb_ws2812b_receiver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ws2812b_receiver_if bus ();
  ws2812b_receiver_if bus2 ();

  ws2812b_receiver dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  ws2812b_receiver #(
    .BIT_THRESH   (2),
    .GLITCH_MAX   (0),
    .LATCH_CYCLES (16),
    .HIGH_TIMEOUT (200)
  ) dut_ovf (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [33:0] wq[$];
  logic [33:0] w2q[$];
  int done_cnt = 0;
  int done2    = 0;
  int overlap  = 0;

  always @(negedge clk) begin
    if (bus.ram_we)     wq.push_back({bus.ram_addr, bus.ram_data});
    if (bus.frame_done) done_cnt++;
    if (bus.ram_we && bus.frame_done) overlap++;
    if (bus2.ram_we)     w2q.push_back({bus2.ram_addr, bus2.ram_data});
    if (bus2.frame_done) done2++;
    if (bus2.ram_we && bus2.frame_done) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold2(input logic v, input int n);
    bus2.din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? 16 : 8);
    hold(1'b0, b ? 9 : 17);
  endtask

  task automatic send_pixel(input logic [23:0] p, input bit glitch);
    for (int i = 23; i >= 0; i--) begin
      send_bit(p[i]);
      if (glitch && i > 0) begin
        hold(1'b1, 2);
        hold(1'b0, 6);
      end
    end
  endtask

  task automatic send_pixel2(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) begin
      hold2(1'b1, p[i] ? 2 : 1);
      hold2(1'b0, 1);
    end
  endtask

  typedef struct {
    int               npix;
    int               nbits;
    logic [2:0][23:0] pix;
    bit               glitch;
    int               exp_pc;
    bit               exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{npix:1, nbits:0,  pix:{24'h0, 24'h0, 24'hA5C33C},         glitch:0, exp_pc:1, exp_err:0};
    vecs[1] = '{npix:3, nbits:0,  pix:{24'h800000, 24'hFFFFFF, 24'h000001}, glitch:0, exp_pc:3, exp_err:0};
    vecs[2] = '{npix:1, nbits:0,  pix:{24'h0, 24'h0, 24'h123456},         glitch:1, exp_pc:1, exp_err:0};
    vecs[3] = '{npix:0, nbits:12, pix:{24'h0, 24'h0, 24'hABC000},         glitch:0, exp_pc:0, exp_err:1};
    vecs[4] = '{npix:1, nbits:0,  pix:{24'h0, 24'h0, 24'h5A5A5A},         glitch:0, exp_pc:1, exp_err:0};

    rst      = 1'b1;
    bus.din  = 1'b0;
    bus2.din = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we",    32'(bus.ram_we),      32'd0);
    check("rst_addr",  32'(bus.ram_addr),    32'd0);
    check("rst_data",  32'(bus.ram_data),    32'd0);
    check("rst_done",  32'(bus.frame_done),  32'd0);
    check("rst_pc",    32'(bus.pixel_count), 32'd0);
    check("rst_err",   32'(bus.error),       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    fork
      begin : main_tests
        hold(1'b0, 1010);
        for (int e = 0; e < 5; e++) begin
          vec_t v;
          v = vecs[e];
          wq.delete();
          done_cnt = 0;
          for (int i = 0; i < v.npix; i++) send_pixel(v.pix[i], v.glitch);
          for (int b = 23; b > 23 - v.nbits; b--) send_bit(v.pix[0][b]);
          hold(1'b0, 1100);
          check($sformatf("v%0d_writes", e), 32'(wq.size()), 32'(v.npix));
          for (int i = 0; i < v.npix && i < wq.size(); i++) begin
            check($sformatf("v%0d_addr%0d", e, i), 32'(wq[i][33:24]), 32'(i));
            check($sformatf("v%0d_data%0d", e, i), 32'(wq[i][23:0]),  32'(v.pix[i]));
          end
          check($sformatf("v%0d_done", e), 32'(done_cnt),        32'd1);
          check($sformatf("v%0d_pc", e),   32'(bus.pixel_count), 32'(v.exp_pc));
          check($sformatf("v%0d_err", e),  32'(bus.error),       32'(v.exp_err));
        end

        done_cnt = 0;
        hold(1'b0, 2100);
        check("idle_no_done", 32'(done_cnt), 32'd0);

        // Line stuck high in the middle of a pixel.
        wq.delete();
        done_cnt = 0;
        for (int b = 23; b > 13; b--) send_bit(1'b1);
        hold(1'b1, 250);
        check("to_err",    32'(bus.error), 32'd1);
        check("to_nowr",   32'(wq.size()), 32'd0);
        hold(1'b0, 300);
        send_pixel(24'hC0FFEE, 1'b0);
        hold(1'b0, 1100);
        check("to_resync_nowr",   32'(wq.size()), 32'd0);
        check("to_resync_nodone", 32'(done_cnt),  32'd0);
        check("to_resync_err",    32'(bus.error), 32'd1);
        send_pixel(24'h0F0F0F, 1'b0);
        hold(1'b0, 1100);
        check("to_after_writes", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) begin
          check("to_after_addr", 32'(wq[0][33:24]), 32'd0);
          check("to_after_data", 32'(wq[0][23:0]),  32'h0F0F0F);
        end
        check("to_after_err", 32'(bus.error),       32'd0);
        check("to_after_pc",  32'(bus.pixel_count), 32'd1);
      end
      begin : overflow_test
        hold2(1'b0, 40);
        w2q.delete();
        done2 = 0;
        for (int i = 0; i < 1025; i++) send_pixel2(24'(i));
        hold2(1'b0, 40);
        begin
          int bad;
          bad = 0;
          for (int i = 0; i < 1024 && i < w2q.size(); i++)
            if (w2q[i] !== {10'(i), 24'(i)}) bad++;
          check("ovf_writes",   32'(w2q.size()),        32'd1024);
          check("ovf_bad_wr",   32'(bad),               32'd0);
          check("ovf_done",     32'(done2),             32'd1);
          check("ovf_pc",       32'(bus2.pixel_count),  32'd1024);
          check("ovf_err",      32'(bus2.error),        32'd1);
        end
      end
    join

    // Reset pulsed in the middle of a pixel.
    wq.delete();
    done_cnt = 0;
    for (int b = 23; b > 11; b--) send_bit(1'b1);
    bus.din = 1'b1;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mr_we",   32'(bus.ram_we),      32'd0);
    check("mr_addr", 32'(bus.ram_addr),    32'd0);
    check("mr_data", 32'(bus.ram_data),    32'd0);
    check("mr_done", 32'(bus.frame_done),  32'd0);
    check("mr_pc",   32'(bus.pixel_count), 32'd0);
    check("mr_err",  32'(bus.error),       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.din = 1'b0;
    for (int b = 11; b >= 0; b--) send_bit(1'b0);
    hold(1'b0, 1100);
    check("mr_nowr",   32'(wq.size()), 32'd0);
    check("mr_nodone", 32'(done_cnt),  32'd0);
    send_pixel(24'h3C3C3C, 1'b0);
    hold(1'b0, 1100);
    check("mr_writes", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      check("mr_wr_addr", 32'(wq[0][33:24]), 32'd0);
      check("mr_wr_data", 32'(wq[0][23:0]),  32'h3C3C3C);
    end
    check("mr_pc_after", 32'(bus.pixel_count), 32'd1);
    check("mr_done_after", 32'(done_cnt), 32'd1);

    check("we_done_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
